// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, CDB capture, operand queries, in-order commit and flush.
// Optional build macro ROB_CDB_BYPASS_EN: queries also forward a same-cycle CDB hit (CDBA priority).
module reorder_buffer #(
    parameter int unsigned ROB_SIZE_LOG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    iss_sgn,
    input  logic [1:0]              iss_kind,
    input  logic                    iss_ready,
    input  logic [31:0]             iss_value,
    input  logic [4:0]              iss_dest,
    input  logic                    iss_jumped,
    input  logic [31:0]             iss_jumpto,
    output logic [ROB_SIZE_LOG-1:0] rob_name,
    output logic                    rob_full,
    input  logic                    cdba_sgn,
    input  logic [31:0]             cdba_result,
    input  logic [ROB_SIZE_LOG-1:0] cdba_rob_name,
    input  logic                    cdbd_sgn,
    input  logic [31:0]             cdbd_result,
    input  logic [ROB_SIZE_LOG-1:0] cdbd_rob_name,
    input  logic [ROB_SIZE_LOG-1:0] qry1_name,
    input  logic [ROB_SIZE_LOG-1:0] qry2_name,
    output logic                    qry1_rdy,
    output logic                    qry2_rdy,
    output logic [31:0]             qry1_val,
    output logic [31:0]             qry2_val,
    output logic                    cmt_sgn,
    output logic [4:0]              cmt_dest,
    output logic [31:0]             cmt_value,
    output logic [ROB_SIZE_LOG-1:0] cmt_rob_name,
    output logic                    st_cmt_sgn,
    output logic [3:0]              st_cmt_lsb,
    output logic                    clear_sgn,
    output logic [31:0]             clear_pc
);
    localparam int unsigned SIZE = 1 << ROB_SIZE_LOG;
    localparam int unsigned CW   = ROB_SIZE_LOG + 1;
    localparam logic [1:0] K_REG = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JALR = 2'd3;

    logic [SIZE-1:0]         r_busy, r_ready, r_taken, r_jumped;
    logic [1:0]              r_kind   [SIZE];
    logic [31:0]             r_value  [SIZE];
    logic [31:0]             r_jumpto [SIZE];
    logic [4:0]              r_dest   [SIZE];
    logic [ROB_SIZE_LOG-1:0] r_head, r_tail;
    logic [CW-1:0]           r_count;

    logic                    r_cmt_sgn, r_st_cmt_sgn, r_clear_sgn;
    logic [4:0]              r_cmt_dest;
    logic [31:0]             r_cmt_value, r_clear_pc;
    logic [ROB_SIZE_LOG-1:0] r_cmt_rob_name;
    logic [3:0]              r_st_cmt_lsb;

    logic                    w_live, w_cmt, w_mispredict, w_flush, w_iss;
    logic [SIZE-1:0]         w_hit_a, w_hit_d;

    // Inputs arriving while the flush pulse is out belong to squashed instructions.
    assign w_live       = ~r_clear_sgn;
    assign w_cmt        = r_busy[r_head] & r_ready[r_head];
    assign w_mispredict = (r_kind[r_head] == K_BR) & (r_taken[r_head] != r_jumped[r_head]);
    assign w_flush      = w_cmt & ((r_kind[r_head] == K_JALR) | w_mispredict);
    assign w_iss        = iss_sgn & w_live & ((r_count != CW'(SIZE)) | w_cmt);

    always_comb begin
        w_hit_a = '0;
        w_hit_d = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (w_live && r_busy[i] && !r_ready[i]) begin
                if (cdba_sgn && cdba_rob_name == ROB_SIZE_LOG'(i))
                    w_hit_a[i] = 1'b1;
                else if (cdbd_sgn && cdbd_rob_name == ROB_SIZE_LOG'(i))
                    w_hit_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_cmt_sgn      <= 1'b0;
            r_st_cmt_sgn   <= 1'b0;
            r_clear_sgn    <= 1'b0;
            r_cmt_dest     <= '0;
            r_cmt_value    <= '0;
            r_cmt_rob_name <= '0;
            r_st_cmt_lsb   <= '0;
            r_clear_pc     <= '0;
        end else if (rdy) begin
            r_cmt_sgn    <= 1'b0;
            r_st_cmt_sgn <= 1'b0;
            r_clear_sgn  <= 1'b0;

            // Result capture: branch keeps its value and records the outcome, JALR records its target.
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (w_hit_a[i] || w_hit_d[i]) begin
                    r_ready[i] <= 1'b1;
                    case (r_kind[i])
                        K_REG:   r_value[i]  <= w_hit_a[i] ? cdba_result : cdbd_result;
                        K_BR:    r_taken[i]  <= w_hit_a[i] ? cdba_result[0] : cdbd_result[0];
                        K_JALR:  r_jumpto[i] <= w_hit_a[i] ? cdba_result : cdbd_result;
                        default: ;
                    endcase
                end
            end

            if (w_cmt) begin
                r_busy[r_head]  <= 1'b0;
                r_ready[r_head] <= 1'b0;
                r_head          <= r_head + ROB_SIZE_LOG'(1);
                case (r_kind[r_head])
                    K_REG: begin
                        r_cmt_sgn      <= 1'b1;
                        r_cmt_dest     <= r_dest[r_head];
                        r_cmt_value    <= r_value[r_head];
                        r_cmt_rob_name <= r_head;
                    end
                    K_ST: begin
                        r_st_cmt_sgn <= 1'b1;
                        r_st_cmt_lsb <= r_dest[r_head][3:0];
                    end
                    K_JALR: begin
                        r_cmt_sgn      <= 1'b1;
                        r_cmt_dest     <= r_dest[r_head];
                        r_cmt_value    <= r_value[r_head];
                        r_cmt_rob_name <= r_head;
                        r_clear_sgn    <= 1'b1;
                        r_clear_pc     <= r_jumpto[r_head];
                    end
                    default: begin
                        if (w_mispredict) begin
                            r_clear_sgn <= 1'b1;
                            r_clear_pc  <= r_jumpto[r_head];
                        end
                    end
                endcase
            end

            // Allocation follows commit so a full-buffer reuse of the head slot wins.
            if (w_iss) begin
                r_busy[r_tail]   <= 1'b1;
                r_ready[r_tail]  <= iss_ready;
                r_kind[r_tail]   <= iss_kind;
                r_value[r_tail]  <= iss_value;
                r_dest[r_tail]   <= iss_dest;
                r_jumped[r_tail] <= iss_jumped;
                r_jumpto[r_tail] <= iss_jumpto;
                r_taken[r_tail]  <= 1'b0;
                r_tail           <= r_tail + ROB_SIZE_LOG'(1);
            end

            if (w_flush) begin
                r_busy  <= '0;
                r_ready <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(w_iss) - CW'(w_cmt);
            end
        end
    end

    always_comb begin
        qry1_rdy = r_busy[qry1_name] & r_ready[qry1_name];
        qry1_val = r_busy[qry1_name] ? r_value[qry1_name] : 32'd0;
        qry2_rdy = r_busy[qry2_name] & r_ready[qry2_name];
        qry2_val = r_busy[qry2_name] ? r_value[qry2_name] : 32'd0;
`ifdef ROB_CDB_BYPASS_EN
        if (w_hit_a[qry1_name] || w_hit_d[qry1_name]) begin
            qry1_rdy = 1'b1;
            if (r_kind[qry1_name] == K_REG)
                qry1_val = w_hit_a[qry1_name] ? cdba_result : cdbd_result;
        end
        if (w_hit_a[qry2_name] || w_hit_d[qry2_name]) begin
            qry2_rdy = 1'b1;
            if (r_kind[qry2_name] == K_REG)
                qry2_val = w_hit_a[qry2_name] ? cdba_result : cdbd_result;
        end
`endif
    end

    assign rob_name     = r_tail;
    assign rob_full     = (r_count >= CW'(SIZE - 1));
    assign cmt_sgn      = r_cmt_sgn;
    assign cmt_dest     = r_cmt_dest;
    assign cmt_value    = r_cmt_value;
    assign cmt_rob_name = r_cmt_rob_name;
    assign st_cmt_sgn   = r_st_cmt_sgn;
    assign st_cmt_lsb   = r_st_cmt_lsb;
    assign clear_sgn    = r_clear_sgn;
    assign clear_pc     = r_clear_pc;
endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus randomized traffic checked against a program-order queue model.
module tb_reorder_buffer;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          iss_sgn, iss_ready, iss_jumped;
    logic [1:0]    iss_kind;
    logic [31:0]   iss_value, iss_jumpto;
    logic [4:0]    iss_dest;
    logic [TW-1:0] rob_name;
    logic          rob_full;
    logic          cdba_sgn, cdbd_sgn;
    logic [31:0]   cdba_result, cdbd_result;
    logic [TW-1:0] cdba_rob_name, cdbd_rob_name, qry1_name, qry2_name;
    logic          qry1_rdy, qry2_rdy;
    logic [31:0]   qry1_val, qry2_val;
    logic          cmt_sgn, st_cmt_sgn, clear_sgn;
    logic [4:0]    cmt_dest;
    logic [31:0]   cmt_value, clear_pc;
    logic [TW-1:0] cmt_rob_name;
    logic [3:0]    st_cmt_lsb;

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_SIZE_LOG(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .iss_sgn(iss_sgn), .iss_kind(iss_kind), .iss_ready(iss_ready), .iss_value(iss_value),
        .iss_dest(iss_dest), .iss_jumped(iss_jumped), .iss_jumpto(iss_jumpto),
        .rob_name(rob_name), .rob_full(rob_full),
        .cdba_sgn(cdba_sgn), .cdba_result(cdba_result), .cdba_rob_name(cdba_rob_name),
        .cdbd_sgn(cdbd_sgn), .cdbd_result(cdbd_result), .cdbd_rob_name(cdbd_rob_name),
        .qry1_name(qry1_name), .qry2_name(qry2_name),
        .qry1_rdy(qry1_rdy), .qry2_rdy(qry2_rdy), .qry1_val(qry1_val), .qry2_val(qry2_val),
        .cmt_sgn(cmt_sgn), .cmt_dest(cmt_dest), .cmt_value(cmt_value), .cmt_rob_name(cmt_rob_name),
        .st_cmt_sgn(st_cmt_sgn), .st_cmt_lsb(st_cmt_lsb),
        .clear_sgn(clear_sgn), .clear_pc(clear_pc)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [1:0]    kind;
        logic          ready;
        logic [31:0]   value;
        logic [4:0]    dest;
        logic          jumped;
        logic [31:0]   jumpto;
        logic          taken;
    } ent_t;

    // In-flight instructions in program order; the oldest sits at index 0.
    ent_t q[$];
    int   next_tag = 0;
    bit   m_clr = 1'b0;
    logic e_cmt = 1'b0, e_st = 1'b0, e_clr = 1'b0;
    logic [4:0]    e_dest = '0;
    logic [31:0]   e_val = '0, e_pc = '0;
    logic [TW-1:0] e_tag = '0;
    logic [3:0]    e_lsb = '0;
    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ent_t cap(input ent_t x, input logic [31:0] r);
        ent_t y = x;
        y.ready = 1'b1;
        case (x.kind)
            2'd0:    y.value  = r;
            2'd1:    y.taken  = r[0];
            2'd3:    y.jumpto = r;
            default: ;
        endcase
        return y;
    endfunction

    task automatic model_step();
        ent_t e;
        bit   flush = 1'b0;
        bit   live;
        if (rst) begin
            q.delete(); next_tag = 0; m_clr = 1'b0;
            e_cmt = 1'b0; e_st = 1'b0; e_clr = 1'b0;
            return;
        end
        if (!rdy) return;
        live = !m_clr;
        e_cmt = 1'b0; e_st = 1'b0; e_clr = 1'b0;
        if (q.size() > 0 && q[0].ready) begin
            e = q.pop_front();
            if (e.kind == 2'd0 || e.kind == 2'd3) begin
                e_cmt = 1'b1; e_dest = e.dest; e_val = e.value; e_tag = e.tag;
            end
            if (e.kind == 2'd2) begin e_st = 1'b1; e_lsb = e.dest[3:0]; end
            if (e.kind == 2'd3 || (e.kind == 2'd1 && e.taken != e.jumped)) begin
                flush = 1'b1; e_clr = 1'b1; e_pc = e.jumpto;
            end
        end
        if (live) begin
            foreach (q[i]) begin
                if (!q[i].ready) begin
                    if (cdba_sgn && cdba_rob_name == q[i].tag)      q[i] = cap(q[i], cdba_result);
                    else if (cdbd_sgn && cdbd_rob_name == q[i].tag) q[i] = cap(q[i], cdbd_result);
                end
            end
            if (iss_sgn) begin
                e.tag = TW'(next_tag); e.kind = iss_kind; e.ready = iss_ready; e.value = iss_value;
                e.dest = iss_dest; e.jumped = iss_jumped; e.jumpto = iss_jumpto; e.taken = 1'b0;
                q.push_back(e);
                next_tag = (next_tag + 1) % 16;
            end
        end
        if (flush) begin q.delete(); next_tag = 0; end
        m_clr = flush;
    endtask

    task automatic check_outputs();
        chk("cmt_sgn", 32'(cmt_sgn), 32'(e_cmt));
        if (e_cmt) begin
            chk("cmt_dest", 32'(cmt_dest), 32'(e_dest));
            chk("cmt_value", cmt_value, e_val);
            chk("cmt_rob_name", 32'(cmt_rob_name), 32'(e_tag));
        end
        chk("st_cmt_sgn", 32'(st_cmt_sgn), 32'(e_st));
        if (e_st) chk("st_cmt_lsb", 32'(st_cmt_lsb), 32'(e_lsb));
        chk("clear_sgn", 32'(clear_sgn), 32'(e_clr));
        if (e_clr) chk("clear_pc", clear_pc, e_pc);
        chk("rob_name", 32'(rob_name), 32'(next_tag));
        chk("rob_full", 32'(rob_full), 32'(q.size() >= 15));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic qcheck(input logic [TW-1:0] t1, input logic [TW-1:0] t2);
        logic r1 = 1'b0, r2 = 1'b0;
        logic [31:0] v1 = '0, v2 = '0;
        qry1_name = t1; qry2_name = t2;
        #1;
        foreach (q[i]) begin
            if (q[i].tag == t1) begin r1 = q[i].ready; v1 = q[i].value; end
            if (q[i].tag == t2) begin r2 = q[i].ready; v2 = q[i].value; end
        end
        chk("qry1_rdy", 32'(qry1_rdy), 32'(r1));
        chk("qry1_val", qry1_val, v1);
        chk("qry2_rdy", 32'(qry2_rdy), 32'(r2));
        chk("qry2_val", qry2_val, v2);
    endtask

    task automatic idle();
        iss_sgn = 1'b0; cdba_sgn = 1'b0; cdbd_sgn = 1'b0;
    endtask

    task automatic issue(input logic [1:0] k, input logic r, input logic [31:0] v,
                         input logic [4:0] d, input logic j, input logic [31:0] jt);
        iss_sgn = 1'b1; iss_kind = k; iss_ready = r; iss_value = v;
        iss_dest = d; iss_jumped = j; iss_jumpto = jt;
    endtask

    function automatic logic [TW-1:0] pick();
        logic [TW-1:0] t = TW'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) begin
            foreach (q[i]) if (!q[i].ready && $urandom_range(0, 1) == 0) t = q[i].tag;
        end
        return t;
    endfunction

    task automatic drain();
        for (int k = 0; k < 64 && q.size() > 0; k++) begin
            idle();
            foreach (q[i]) begin
                if (!q[i].ready && !cdba_sgn) begin
                    cdba_sgn = 1'b1; cdba_rob_name = q[i].tag; cdba_result = $urandom();
                end
            end
            step();
        end
        idle();
        step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; idle();
        issue(2'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0); iss_sgn = 1'b0;
        cdba_result = '0; cdbd_result = '0; cdba_rob_name = '0; cdbd_rob_name = '0;
        qry1_name = '0; qry2_name = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_cmt_sgn", 32'(cmt_sgn), 32'd0);
        chk("rst_cmt_value", cmt_value, 32'd0);
        chk("rst_rob_name", 32'(rob_name), 32'd0);
        chk("rst_rob_full", 32'(rob_full), 32'd0);
        chk("rst_clear_pc", clear_pc, 32'd0);
        chk("rst_qry1_rdy", 32'(qry1_rdy), 32'd0);

        // Ready-at-issue REG commits the following cycle.
        issue(2'd0, 1'b1, 32'h1234, 5'd5, 1'b0, 32'd0); step();
        chk("t1_rob_name", 32'(rob_name), 32'd1);
        idle(); step();
        chk("t1_cmt_sgn", 32'(cmt_sgn), 32'd1);
        chk("t1_cmt_value", cmt_value, 32'h1234);
        chk("t1_cmt_tag", 32'(cmt_rob_name), 32'd0);

        // Fill to the full threshold, then free one slot.
        for (int i = 0; i < 15; i++) begin
            issue(2'd0, 1'b0, 32'(i), 5'(i + 1), 1'b0, 32'd0); step();
        end
        idle();
        chk("t2_full", 32'(rob_full), 32'd1);
        cdba_sgn = 1'b1; cdba_rob_name = q[0].tag; cdba_result = 32'hBEEF; step();
        idle(); step();
        chk("t2_cmt_value", cmt_value, 32'hBEEF);
        chk("t2_not_full", 32'(rob_full), 32'd0);
        drain();

        // Mispredicted branch flushes younger work; issue during the flush pulse is dropped.
        issue(2'd1, 1'b0, 32'd0, 5'd0, 1'b0, 32'h100); step();
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, 1'b1, 32'hA0 + 32'(i), 5'd7, 1'b0, 32'd0); step();
        end
        idle(); cdba_sgn = 1'b1; cdba_rob_name = q[0].tag; cdba_result = 32'd1; step();
        idle(); step();
        chk("t3_clear", 32'(clear_sgn), 32'd1);
        chk("t3_clear_pc", clear_pc, 32'h100);
        chk("t3_rob_name", 32'(rob_name), 32'd0);
        issue(2'd0, 1'b1, 32'h55, 5'd9, 1'b0, 32'd0); step();
        chk("t3_drop_iss", 32'(rob_name), 32'd0);
        issue(2'd0, 1'b1, 32'h66, 5'd9, 1'b0, 32'd0); step();
        idle(); step();
        chk("t3_post_flush", cmt_value, 32'h66);

        // CDBA beats CDBD on the same tag.
        issue(2'd0, 1'b0, 32'd0, 5'd4, 1'b0, 32'd0); step();
        idle(); cdba_sgn = 1'b1; cdbd_sgn = 1'b1;
        cdba_rob_name = q[0].tag; cdbd_rob_name = q[0].tag; cdba_result = 32'd7; cdbd_result = 32'd9;
        step();
        idle(); step();
        chk("t4_cdba_wins", cmt_value, 32'd7);

        // Store blocks a younger ready REG until its address resolves.
        issue(2'd2, 1'b0, 32'h5A5A, 5'd3, 1'b0, 32'd0); step();
        issue(2'd0, 1'b1, 32'hABC, 5'd2, 1'b0, 32'd0); step();
        idle(); step();
        cdbd_sgn = 1'b1; cdbd_rob_name = q[0].tag; cdbd_result = 32'h400; step();
        idle(); step();
        chk("t5_st_sgn", 32'(st_cmt_sgn), 32'd1);
        chk("t5_st_lsb", 32'(st_cmt_lsb), 32'd3);
        step();
        chk("t5_reg_after", cmt_value, 32'hABC);

        // Long ready stream across the tag wrap, with a freeze in the middle.
        for (int i = 0; i < 40; i++) begin
            issue(2'd0, 1'b1, $urandom(), 5'($urandom_range(0, 31)), 1'b0, 32'd0);
            if (i >= 20 && i < 23) begin
                rdy = 1'b0; cdba_sgn = 1'b1; cdba_rob_name = TW'(i); cdba_result = $urandom();
            end else begin
                rdy = 1'b1; cdba_sgn = 1'b0;
            end
            step();
        end
        rdy = 1'b1; drain();

        // Randomized traffic with queries, freezes and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            int r = $urandom_range(0, 7);
            rdy = ($urandom_range(0, 9) != 0);
            rst = (c == 300);
            iss_sgn = (q.size() < 15) && ($urandom_range(0, 2) != 0);
            iss_kind = (r < 4) ? 2'd0 : (r < 6) ? 2'd2 : (r == 6) ? 2'd1 : 2'd3;
            iss_ready = (iss_kind == 2'd0 || iss_kind == 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
            iss_value = $urandom(); iss_dest = 5'($urandom_range(0, 31));
            iss_jumped = 1'($urandom_range(0, 1)); iss_jumpto = $urandom();
            cdba_sgn = 1'($urandom_range(0, 1)); cdba_rob_name = pick(); cdba_result = $urandom();
            cdbd_sgn = 1'($urandom_range(0, 1)); cdbd_rob_name = pick(); cdbd_result = $urandom();
            step();
            qcheck(TW'($urandom_range(0, 15)), pick());
        end
        rst = 1'b0; rdy = 1'b1; drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
